// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and load/store requesters onto one single-ported RAM.
// Define ARB_RR_EN for round-robin tie-break; default build gives the data port fixed priority.
module mem_port_arbiter #(
  parameter int RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ready,
  output logic        if_resp,
  output logic [63:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_wmask,
  output logic        mem_ready,
  output logic        mem_resp,
  output logic [63:0] mem_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wdata,
  output logic [7:0]  ram_wmask,
  input  logic [63:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      r_state;
  logic        r_port_mem;
  logic [1:0]  r_cnt;
  logic        r_ram_en;
  logic        r_ram_we;
  logic [63:0] r_ram_addr;
  logic [63:0] r_ram_wdata;
  logic [7:0]  r_ram_wmask;
  logic        r_if_resp;
  logic        r_mem_resp;
  logic [63:0] r_if_rdata;
  logic [63:0] r_mem_rdata;

  logic        w_idle;
  logic        w_pick_mem;
  logic        w_if_hs;
  logic        w_mem_hs;

`ifdef ARB_RR_EN
  logic r_last_mem;

  // On a tie the port that did not win last time goes first.
  assign w_pick_mem = mem_req && (!if_req || !r_last_mem);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_mem <= 1'b1;
    end else if (w_mem_hs) begin
      r_last_mem <= 1'b1;
    end else if (w_if_hs) begin
      r_last_mem <= 1'b0;
    end
  end
`else
  assign w_pick_mem = mem_req;
`endif

  assign w_idle    = rst && (r_state == IDLE);
  assign w_mem_hs  = w_idle && w_pick_mem;
  assign w_if_hs   = w_idle && if_req && !w_pick_mem;
  assign if_ready  = w_if_hs;
  assign mem_ready = w_mem_hs;

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_wmask = r_ram_wmask;
  assign if_resp   = r_if_resp;
  assign if_rdata  = r_if_rdata;
  assign mem_resp  = r_mem_resp;
  assign mem_rdata = r_mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_port_mem  <= 1'b0;
      r_cnt       <= 2'd0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= 64'd0;
      r_ram_wdata <= 64'd0;
      r_ram_wmask <= 8'd0;
      r_if_resp   <= 1'b0;
      r_mem_resp  <= 1'b0;
      r_if_rdata  <= 64'd0;
      r_mem_rdata <= 64'd0;
    end else begin
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_if_resp  <= 1'b0;
      r_mem_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_mem_hs) begin
            r_state     <= ISSUE;
            r_port_mem  <= 1'b1;
            r_ram_en    <= 1'b1;
            r_ram_we    <= mem_we;
            r_ram_addr  <= mem_addr;
            r_ram_wdata <= mem_we ? mem_wdata : 64'd0;
            r_ram_wmask <= mem_we ? mem_wmask : 8'd0;
          end else if (w_if_hs) begin
            r_state     <= ISSUE;
            r_port_mem  <= 1'b0;
            r_ram_en    <= 1'b1;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= if_addr;
            r_ram_wdata <= 64'd0;
            r_ram_wmask <= 8'd0;
          end
        end
        ISSUE: begin
          // Only the data port can store, so a write always completes on mem_resp.
          if (r_ram_we) begin
            r_state     <= RESP;
            r_mem_resp  <= 1'b1;
            r_mem_rdata <= 64'd0;
          end else begin
            r_state <= WAIT;
            r_cnt   <= 2'(RAM_LAT - 1);
          end
        end
        WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state <= RESP;
            if (r_port_mem) begin
              r_mem_resp  <= 1'b1;
              r_mem_rdata <= ram_rdata;
            end else begin
              r_if_resp  <= 1'b1;
              r_if_rdata <= ram_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported 64-bit instruction/data RAM between the instruction-fetch requester (if_stage) and the load/store requester (datamem) of the core. Each request is accepted with a valid/ready handshake, issued to the RAM as a one-cycle access, and its read data or write completion is returned to the granted requester only. The block sits between the two requesters and the RAM model, below the SimTop core wiring.

## Interface

Parameters:
- RAM_LAT, 1: cycles from `ram_en` (read) to valid `ram_rdata`; legal range 1..4.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low; one clock, reset is synchronous and active-low.
- if_req  input  1  fetch request; held stable until `if_ready`.
- if_addr  input  64  fetch byte address.
- if_ready  output  1  fetch request accepted this cycle.
- if_resp  output  1  one-cycle pulse: `if_rdata` valid.
- if_rdata  output  64  fetch read data.
- mem_req  input  1  load/store request; held stable until `mem_ready`.
- mem_we  input  1  1 = store, 0 = load.
- mem_addr  input  64  load/store byte address.
- mem_wdata  input  64  store data.
- mem_wmask  input  8  store byte enables.
- mem_ready  output  1  load/store request accepted this cycle.
- mem_resp  output  1  one-cycle pulse: load data valid or store complete.
- mem_rdata  output  64  load data; 0 on store completion.
- ram_en  output  1  RAM access strobe, one cycle per access.
- ram_we  output  1  RAM write enable, qualified by `ram_en`.
- ram_addr  output  64  RAM address, passed unchanged from the requester.
- ram_wdata  output  64  RAM write data.
- ram_wmask  output  8  RAM byte enables; 0 on reads.
- ram_rdata  input  64  RAM read data, valid RAM_LAT cycles after a read `ram_en`.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is pending, pick a winner. `if_ready`/`mem_ready` are combinational, high only in IDLE and only for the winner. On the handshake, capture the port ID, we, addr, wdata, and wmask, then go to ISSUE. With no request, stay in IDLE.
- ISSUE: drive `ram_en`=1 and the captured `ram_we/addr/wdata/wmask` for exactly one cycle. A store goes to RESP. A load goes to WAIT and loads the latency counter with RAM_LAT-1.
- WAIT: decrement the counter. When it is 0, sample `ram_rdata` into the response register and go to RESP. With RAM_LAT=1, WAIT lasts one cycle.
- RESP: pulse `*_resp` on the owning port only, with the registered data. Store responses carry `mem_rdata`=0. The FSM returns to IDLE, and new arbitration happens in the cycle after RESP.
- Tie-break (both requests in IDLE): data port wins. See Configuration for the alternative.
- Either requester may deassert its request before receiving ready. There is no side effect in that case.
- The non-granted port's request is untouched and is re-arbitrated at the next IDLE.
- The captured request is not altered by input changes after the handshake.

## Timing

- Reset values (rst=0 at a clock edge): state=IDLE. All outputs are 0: `if_ready`, `mem_ready`, `if_resp`, `mem_resp`, `if_rdata`, `mem_rdata`, `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, `ram_wmask`. The RR pointer is reset as described under Configuration.
- Reset mid-operation: the in-flight access is aborted. No `*_resp` is issued, and a late `ram_rdata` is ignored.
- Handshake at cycle N:
  - `ram_en` in cycle N+1.
  - Load response in cycle N+2+RAM_LAT.
  - Store response in cycle N+2.
- Next handshake is possible, at the earliest, in the cycle after the response.
- Throughput: one access per 3 cycles for a store, or 3+RAM_LAT cycles for a load.
- `ram_en` is never high in two consecutive cycles. At most one `*_resp` is high per cycle.

## Configuration

- `ARB_RR_EN` defined: round-robin tie-break.
  - A 1-bit `last_grant` is updated on every handshake.
  - On a tie, the port not granted last wins.
  - Reset value of `last_grant` is the data port, so the first tie goes to fetch.
- `ARB_RR_EN` undefined: fixed priority, data port always wins ties, and `last_grant` is not built.

## Test plan

- Single fetch, RAM_LAT=1: `if_req`, `if_addr`=0x80000000, RAM returns 0x00000013.
  - `if_ready` at N, `ram_en`/`ram_addr`=0x80000000 at N+1, `if_resp` with `if_rdata`=0x13 at N+3.
  - `mem_resp` stays 0.
- Store then load, RAM_LAT=2: store 0xDEADBEEF to 0x80001000 with `mem_wmask`=0x0F.
  - `ram_we`=1 and `ram_wmask`=0x0F at N+1, `mem_resp` with `mem_rdata`=0 at N+2.
  - A load from the same address, handshaken at N+3, responds at N+7 with the RAM value.
- Simultaneous requests held for 4 grants:
  - Without `ARB_RR_EN`: grants in order mem, mem, mem, mem while `mem_req` stays high.
  - With `ARB_RR_EN`: grants in order if, mem, if, mem.
- Request withdrawn: assert `if_req` during a busy load, then drop it before IDLE. There is no `if_ready` and no extra `ram_en`.
- Reset mid-load: assert rst=0 in WAIT with RAM_LAT=4.
  - All outputs are 0 the next cycle.
  - There is no `mem_resp` afterwards, even though `ram_rdata` changes.
- Protocol checker over random traffic:
  - `ram_en` never high in two consecutive cycles.
  - Exactly one response per handshake, returned on the granting port.
